// File: rtl/ov7670_pkg.sv
// Shared types and default 100 MHz timing for the OV7670 power-up sequencer.
// Holds the state encoding and the per-state output table.
package ov7670_pkg;

  localparam int DEF_LOCK_STABLE_CYCLES = 1000;      // 10 us
  localparam int DEF_PWDN_CYCLES        = 100000;    // 1 ms
  localparam int DEF_CAM_RST_CYCLES     = 100000;    // 1 ms
  localparam int DEF_SETTLE_CYCLES      = 300000;    // 3 ms
  localparam int DEF_CFG_TIMEOUT        = 10000000;  // 100 ms
  localparam int DEF_MAX_RETRIES        = 2;

  typedef enum logic [3:0] {
    ST_WAIT_LOCK   = 4'd0,
    ST_LOCK_STABLE = 4'd1,
    ST_CAM_PWDN    = 4'd2,
    ST_CAM_RESET   = 4'd3,
    ST_CAM_SETTLE  = 4'd4,
    ST_CFG_START   = 4'd5,
    ST_CFG_WAIT    = 4'd6,
    ST_RUN         = 4'd7,
    ST_FAULT       = 4'd8
  } state_t;

  typedef struct packed {
    logic sys_rst_n;
    logic cam_pwdn;
    logic cam_rst_n;
    logic cfg_start;
    logic ready;
    logic fault;
  } outs_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Output vector order: sys_rst_n, cam_pwdn, cam_rst_n, cfg_start, ready, fault.
  function automatic outs_t state_outs(input state_t s);
    case (s)
      ST_CAM_PWDN:   return outs_t'(6'b110000);
      ST_CAM_RESET:  return outs_t'(6'b100000);
      ST_CAM_SETTLE: return outs_t'(6'b101000);
      ST_CFG_START:  return outs_t'(6'b101100);
      ST_CFG_WAIT:   return outs_t'(6'b101000);
      ST_RUN:        return outs_t'(6'b101010);
      ST_FAULT:      return outs_t'(6'b110001);
      default:       return outs_t'(6'b010000);
    endcase
  endfunction

endpackage

// File: rtl/ov7670_power_seq_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared by a
// synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge, giving a true two-stage pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ov7670_power_seq.sv
// Power-up / reset sequencer: waits for stable PLL lock, walks the OV7670
// PWDN/RESET pins through power-up, starts SCCB config and retries on timeout.
module ov7670_power_seq
  import ov7670_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int PWDN_CYCLES        = DEF_PWDN_CYCLES,
  parameter int CAM_RST_CYCLES     = DEF_CAM_RST_CYCLES,
  parameter int SETTLE_CYCLES      = DEF_SETTLE_CYCLES,
  parameter int CFG_TIMEOUT        = DEF_CFG_TIMEOUT,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic cfg_done,
  output logic sys_rst_n,
  output logic cam_pwdn,
  output logic cam_rst_n,
  output logic cfg_start,
  output logic ready,
  output logic fault
);

  localparam int MAX_T   = imax(imax(imax(LOCK_STABLE_CYCLES, PWDN_CYCLES),
                                     imax(CAM_RST_CYCLES, SETTLE_CYCLES)), CFG_TIMEOUT);
  localparam int CNT_W   = $clog2(MAX_T) + 1;
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic               lock_s;
  state_t             state, nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry_cnt, retry_nxt;
  logic               cnt_clr;
  outs_t              outs;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    nxt       = state;
    retry_nxt = retry_cnt;
    if (!lock_s) begin
      nxt       = ST_WAIT_LOCK;
      retry_nxt = '0;
    end else begin
      case (state)
        ST_WAIT_LOCK:   nxt = ST_LOCK_STABLE;
        ST_LOCK_STABLE: if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) nxt = ST_CAM_PWDN;
        ST_CAM_PWDN:    if (cnt == CNT_W'(PWDN_CYCLES - 1))        nxt = ST_CAM_RESET;
        ST_CAM_RESET:   if (cnt == CNT_W'(CAM_RST_CYCLES - 1))     nxt = ST_CAM_SETTLE;
        ST_CAM_SETTLE:  if (cnt == CNT_W'(SETTLE_CYCLES - 1))      nxt = ST_CFG_START;
        ST_CFG_START:   nxt = ST_CFG_WAIT;
        ST_CFG_WAIT: begin
          // A done arriving on the last timeout cycle still counts as success.
          if (cfg_done) begin
            nxt = ST_RUN;
          end else if (cnt == CNT_W'(CFG_TIMEOUT - 1)) begin
            if (retry_cnt == RETRY_W'(MAX_RETRIES)) begin
              nxt = ST_FAULT;
            end else begin
              retry_nxt = retry_cnt + RETRY_W'(1);
              nxt       = ST_CAM_PWDN;
            end
          end
        end
        ST_RUN, ST_FAULT: nxt = state;
        default:          nxt = ST_WAIT_LOCK;
      endcase
    end
  end

  // Counter restarts on every state change and idles at zero in untimed states.
  assign cnt_clr = (nxt != state) || (nxt inside {ST_WAIT_LOCK, ST_RUN, ST_FAULT});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_WAIT_LOCK;
      cnt       <= '0;
      retry_cnt <= '0;
      outs      <= state_outs(ST_WAIT_LOCK);
    end else begin
      state     <= nxt;
      cnt       <= cnt_clr ? '0 : cnt + CNT_W'(1);
      retry_cnt <= retry_nxt;
      outs      <= state_outs(nxt);
    end
  end

  assign sys_rst_n = outs.sys_rst_n;
  assign cam_pwdn  = outs.cam_pwdn;
  assign cam_rst_n = outs.cam_rst_n;
  assign cfg_start = outs.cfg_start;
  assign ready     = outs.ready;
  assign fault     = outs.fault;

endmodule

// File: tb/tb_ov7670_power_seq.sv
// Self-checking bench for ov7670_power_seq: each scenario pushes the expected
// per-cycle output trace (plus the stimulus for the following cycle) to a queue.
module tb_ov7670_power_seq;

  localparam int LS = 16, PW = 8, CR = 8, STL = 32, TO = 64, MR = 2;

  // Output vector order: sys_rst_n, cam_pwdn, cam_rst_n, cfg_start, ready, fault.
  localparam logic [5:0] O_WAIT   = 6'b010000;
  localparam logic [5:0] O_CPWDN  = 6'b110000;
  localparam logic [5:0] O_CRST   = 6'b100000;
  localparam logic [5:0] O_SETTLE = 6'b101000;
  localparam logic [5:0] O_START  = 6'b101100;
  localparam logic [5:0] O_CWAIT  = 6'b101000;
  localparam logic [5:0] O_RUN    = 6'b101010;
  localparam logic [5:0] O_FAULT  = 6'b110001;

  logic clk = 1'b0;
  logic rst_n, pll_locked, cfg_done;
  logic sys_rst_n, cam_pwdn, cam_rst_n, cfg_start, ready, fault;

  typedef struct {
    logic [5:0] outs;
    logic       lock;
    logic       done;
    logic       rst;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ov7670_power_seq #(
    .LOCK_STABLE_CYCLES (LS),
    .PWDN_CYCLES        (PW),
    .CAM_RST_CYCLES     (CR),
    .SETTLE_CYCLES      (STL),
    .CFG_TIMEOUT        (TO),
    .MAX_RETRIES        (MR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .cfg_done   (cfg_done),
    .sys_rst_n  (sys_rst_n),
    .cam_pwdn   (cam_pwdn),
    .cam_rst_n  (cam_rst_n),
    .cfg_start  (cfg_start),
    .ready      (ready),
    .fault      (fault)
  );

  // Push n expected cycles; lock/done/rst are driven right after each of them.
  task automatic push_n(input logic [5:0] o, input int n, input logic lock = 1'b1,
                        input logic done = 1'b0, input logic rst = 1'b1);
    exp_t e;
    e.outs = o; e.lock = lock; e.done = done; e.rst = rst;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // One camera attempt from CAM_PWDN entry through wait_n CFG_WAIT cycles.
  task automatic push_attempt(input int wait_n, input logic done_last);
    push_n(O_CPWDN, PW);
    push_n(O_CRST, CR);
    push_n(O_SETTLE, STL);
    push_n(O_START, 1);
    push_n(O_CWAIT, wait_n - 1);
    push_n(O_CWAIT, 1, 1'b1, done_last);
  endtask

  task automatic pump(input string name);
    exp_t       e;
    logic [5:0] got;
    int         idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk);
      #1;
      got = {sys_rst_n, cam_pwdn, cam_rst_n, cfg_start, ready, fault};
      n_checks++;
      if (got !== e.outs) begin
        n_fail++;
        $display("FAIL %s cycle %0d: outputs got %b expected %b", name, idx, got, e.outs);
      end
      pll_locked = e.lock;
      cfg_done   = e.done;
      rst_n      = e.rst;
      idx++;
    end
  endtask

  task automatic check_retry(input string name, input int expv);
    n_checks++;
    if (dut.retry_cnt !== 2'(expv)) begin
      n_fail++;
      $display("FAIL %s retry_cnt got %0d expected %0d", name, dut.retry_cnt, expv);
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst_n = 1'b0; pll_locked = 1'b0; cfg_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = {sys_rst_n, cam_pwdn, cam_rst_n, cfg_start, ready, fault};
    n_checks++;
    if (got !== O_WAIT) begin
      n_fail++;
      $display("FAIL reset outputs got %b expected %b", got, O_WAIT);
    end
    check_retry("reset", 0);
    rst_n = 1'b1;
    push_n(O_WAIT, 3, 1'b0);
    pump("reset_idle");
  endtask

  task automatic test_bringup();
    pll_locked = 1'b1;
    push_n(O_WAIT, 2 + LS);
    push_attempt(5, 1'b1);
    push_n(O_RUN, 2, 1'b1, 1'b1);
    push_n(O_RUN, 2);
    pump("bringup");
    check_retry("bringup", 0);
  endtask

  task automatic test_lock_glitch();
    pll_locked = 1'b0;
    push_n(O_RUN, 2, 1'b0);
    push_n(O_WAIT, 2, 1'b0);
    push_n(O_WAIT, 1);
    push_n(O_WAIT, 12);
    push_n(O_WAIT, 3, 1'b0);
    push_n(O_WAIT, 19);
    pump("lock_glitch");
  endtask

  task automatic test_timeout_retry();
    for (int a = 0; a <= MR; a++) push_attempt(TO, 1'b0);
    push_n(O_FAULT, 4);
    pump("timeout_retry");
    check_retry("timeout_retry", MR);
  endtask

  task automatic test_collision();
    pll_locked = 1'b0;
    push_n(O_FAULT, 2, 1'b0);
    push_n(O_WAIT, 2, 1'b0);
    push_n(O_WAIT, 1);
    pump("fault_lock_loss");
    check_retry("fault_lock_loss", 0);
    push_n(O_WAIT, 2 + LS);
    push_attempt(TO, 1'b0);
    push_attempt(TO, 1'b1);
    push_n(O_RUN, 3);
    pump("collision");
    check_retry("collision", 1);
  endtask

  task automatic test_lock_loss_run();
    pll_locked = 1'b0;
    push_n(O_RUN, 2, 1'b0);
    push_n(O_WAIT, 3, 1'b0);
    pump("lock_loss_run");
    check_retry("lock_loss_run", 0);
  endtask

  task automatic test_rst_mid();
    pll_locked = 1'b1;
    push_n(O_WAIT, 2 + LS);
    push_n(O_CPWDN, PW);
    push_n(O_CRST, 2);
    push_n(O_CRST, 1, 1'b1, 1'b0, 1'b0);
    push_n(O_WAIT, 1);
    pump("rst_mid_cam_reset");
    check_retry("rst_mid_cam_reset", 0);
    push_n(O_WAIT, 2 + LS);
    push_attempt(5, 1'b1);
    push_n(O_RUN, 3);
    pump("rst_mid_restart");
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_glitch();
    test_timeout_retry();
    test_collision();
    test_lock_loss_run();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
